obj_ram_arbiter: RTL and testbench
==================================

Name: obj_ram_arbiter

Overview:
- Shares one synchronous single-port object-state RAM between N_REQ game-logic requesters:
  - 0 = VGA sprite renderer
  - 1 = player controller
  - 2 = missile controller
  - 3 = alien-fleet controller
- Requester 0 has fixed priority. Requesters 1..N_REQ-1 are served round-robin.
- An optional lock gives atomic read-modify-write bursts. A lock timeout keeps any requester from starving the others.
- Sits between the game controllers and the object RAM, under the top level.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 8, object RAM address width.
- DATA_W, 16, object RAM data width.
- LOCK_MAX, 16, maximum consecutive granted cycles under lock (2..255).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester access request; held until granted.
- lock  in  N_REQ  per-requester: keep grant while high.
- we  in  N_REQ  per-requester write enable (0 = read).
- addr  in  N_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- wdata  in  N_REQ*DATA_W  packed write data, same packing.
- gnt  out  N_REQ  registered one-hot grant; the access happens in the cycle gnt[i] is high.
- rvalid  out  N_REQ  one-cycle pulse: rdata is valid for requester i.
- rdata  out  DATA_W  registered read data, shared by all requesters.
- lock_timeout  out  1  one-cycle pulse when a lock is forcibly broken.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid one cycle after the address.

Behaviour:
- Interface: one clock Clk; reset Reset_n is asynchronous, active-low. All flops clear immediately on Reset_n=0.
- Reset values:
  - gnt=0, rvalid=0, rdata=0, lock_timeout=0.
  - ram_we=0 (ram_addr and ram_wdata are 0 because no grant is active).
  - rr_ptr=N_REQ-1, so the first round-robin pick is requester 1.
  - lock_cnt=0.
- Arbitration states: IDLE, GRANT, LOCKED. Next gnt is computed from cycle-t inputs and registered for cycle t+1.
  - IDLE (gnt=0): any req moves to GRANT. req[0] wins if high. Otherwise the first req[j] with j in 1..N_REQ-1, searching from rr_ptr+1 and wrapping, wins.
  - GRANT, owner i:
    - If lock[i] and req[i] are high: go to LOCKED, keep gnt[i], lock_cnt=1.
    - Otherwise: release. Owner i is excluded from this arbitration, and the next winner or IDLE is chosen among the others.
    - A non-locked requester gets at most one access per two cycles when contended.
  - LOCKED, owner i:
    - Keep gnt[i] while lock[i]&req[i] and lock_cnt<LOCK_MAX-1; lock_cnt increments each cycle.
    - On lock_cnt reaching LOCK_MAX-1 with lock still high: pulse lock_timeout the next cycle and force release. The next grant excludes i.
    - req[0] does not preempt a lock.
- rr_ptr updates to j only when a requester j≥1 is granted. Grants to requester 0 leave rr_ptr unchanged.
- RAM port (combinational from registered gnt):
  - ram_addr and ram_wdata = owner's addr/wdata.
  - ram_we = gnt[i]&req[i]&we[i].
  - When gnt=0: ram_addr=0, ram_wdata=0, ram_we=0.
  - If the owner drops req while granted, no access is performed and no rvalid is produced.
- Read latency:
  - Read granted at cycle t (gnt[i]&req[i]&~we[i]).
  - rdata captures ram_rdata at the t+1→t+2 edge.
  - rvalid[i]=1 for cycle t+2 only.
  - Writes produce no rvalid.
- Back-to-back: reads on consecutive cycles, possibly by different owners, produce consecutive rvalid pulses in order.
- Simultaneous events:
  - req[0] and req[j] together from IDLE: 0 wins; j is granted the following cycle.
  - All requesters high continuously: sequence 0,1,0,2,0,3,... Owner exclusion forces a non-0 winner after every 0 grant.
- Reset mid-operation: gnt, rvalid, lock state and in-flight reads are discarded; no rvalid after reset release. Arbitration restarts at IDLE with rr_ptr=N_REQ-1.

Test Plan:
- Reset with req=4'b1111 held; release Reset_n -> gnt=0001 in the first cycle after release, then 0010, 0001, 0100, 0001, 1000.
- Requester 2 reads addr 0x15 (RAM holds 0x1234 there), only req[2] high -> gnt[2] at t, ram_addr=0x15 at t, rvalid[2]=1 and rdata=0x1234 at t+2 only.
- Requester 1 writes 0xBEEF to 0x07 -> ram_we=1, ram_addr=0x07, ram_wdata=0xBEEF for exactly one cycle; no rvalid; a later read of 0x07 returns 0xBEEF.
- Requester 3 holds lock&req with req[0] also high, LOCK_MAX=16 -> gnt[3] for 16 consecutive cycles, then lock_timeout pulses one cycle and gnt=0001 next.
- Requester 1 releases lock after 3 cycles -> gnt[1] for exactly 3 cycles, next grant follows round-robin from rr_ptr=1.
- Assert Reset_n=0 the cycle after a read grant -> rvalid never pulses, all outputs 0; normal arbitration resumes after release.

Source files
------------

// File: rtl/obj_ram_arbiter.sv
// obj_ram_arbiter: shares one single-port object RAM between N_REQ requesters;
// requester 0 has fixed priority, the rest rotate, with lock bursts bounded by a timeout.
module obj_ram_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int LOCK_MAX = 16
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      lock_timeout,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic                      ram_we,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata
);
    localparam int OW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

    state_t           state;
    logic [OW-1:0]    own, rr_ptr, rd_own, win;
    logic [7:0]       lock_cnt;
    logic [N_REQ-1:0] cand;
    logic             busy, acc, hold, timeout, win_ok, rd_pend;
    int               idx;

    always_comb begin
        busy    = state != IDLE;
        acc     = busy && req[own];
        hold    = busy && lock[own] && req[own];
        timeout = state == LOCKED && hold && lock_cnt >= 8'(LOCK_MAX - 1);
        cand    = req;
        if (busy) cand[own] = 1'b0;
        win     = '0;
        win_ok  = cand[0];
        idx     = 0;
        // rotate over 1..N_REQ-1 starting just after the last non-zero winner
        for (int k = 1; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) - 1 + k) % (N_REQ - 1) + 1;
            if (!win_ok && cand[idx]) begin
                win    = OW'(idx);
                win_ok = 1'b1;
            end
        end
        ram_addr  = busy ? addr[int'(own)*ADDR_W +: ADDR_W] : '0;
        ram_wdata = busy ? wdata[int'(own)*DATA_W +: DATA_W] : '0;
        ram_we    = acc && we[own];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            gnt          <= '0;
            own          <= '0;
            rr_ptr       <= OW'(N_REQ - 1);
            lock_cnt     <= '0;
            lock_timeout <= 1'b0;
            rd_pend      <= 1'b0;
            rd_own       <= '0;
            rvalid       <= '0;
            rdata        <= '0;
        end else begin
            lock_timeout <= timeout;
            rd_pend      <= acc && !we[own];
            rd_own       <= own;
            rvalid       <= rd_pend ? ONE << rd_own : '0;
            if (rd_pend) rdata <= ram_rdata;
            if (hold && !timeout) begin
                state    <= LOCKED;
                lock_cnt <= state == LOCKED ? lock_cnt + 8'd1 : 8'd1;
            end else begin
                state    <= win_ok ? GRANT : IDLE;
                gnt      <= win_ok ? ONE << win : '0;
                own      <= win;
                lock_cnt <= '0;
                if (win_ok && win != '0) rr_ptr <= win;
            end
        end
    end
endmodule

// File: tb/tb_obj_ram_arbiter.sv
// tb_obj_ram_arbiter: directed stimulus with queued expectations checked by a monitor.
module tb_obj_ram_arbiter;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [3:0]  req = '0, lock = '0, we = '0;
    logic [31:0] addr = {8'h40, 8'h15, 8'h07, 8'h20};
    logic [63:0] wdata = {16'hC3C3, 16'hB2B2, 16'hBEEF, 16'hA0A0};
    logic [3:0]  gnt, rvalid;
    logic [15:0] rdata, ram_wdata, ram_rdata;
    logic        lock_timeout, ram_we;
    logic [7:0]  ram_addr;

    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic [63:0] gq [$];
    logic [63:0] rq [$];
    int          tq [$];
    logic [63:0] ge, re;
    int          te;
    int          cyc_n = 0;
    int          n_tests = 0, n_fail = 0;

    obj_ram_arbiter dut (
        .Clk(Clk), .Reset_n(Reset_n), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .lock_timeout(lock_timeout), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc_n <= cyc_n + 1;

    always @(posedge Clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc_n);
        end
    endtask

    always @(negedge Clk) begin
        if (|gnt || ram_we) begin
            if (gq.size() == 0) chk("gnt_unexpected", {28'd0, gnt, ram_addr, ram_we, ram_wdata}, 0);
            else begin
                ge = gq.pop_front();
                chk("gnt_cycle", {32'(cyc_n), gnt, ram_addr, ram_we, ram_wdata}, ge);
            end
        end
        if (|rvalid) begin
            if (rq.size() == 0) chk("rvalid_unexpected", {44'd0, rvalid, rdata}, 0);
            else begin
                re = rq.pop_front();
                chk("read_resp", {12'd0, 32'(cyc_n), rvalid, rdata}, re);
            end
        end
        if (lock_timeout) begin
            if (tq.size() == 0) chk("lock_timeout_unexpected", 64'(lock_timeout), 0);
            else begin
                te = tq.pop_front();
                chk("lock_timeout_cycle", 64'(cyc_n), 64'(te));
            end
        end
    end

    // one clock of stimulus; own is the requester expected to hold gnt during it
    task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic [3:0] w,
                         input int own, input bit nord = 1'b0);
        logic [7:0]  a;
        logic [15:0] d;
        req = r; lock = l; we = w;
        if (own >= 0) begin
            a = addr[own*8 +: 8];
            d = wdata[own*16 +: 16];
            gq.push_back({32'(cyc_n), 4'(1 << own), a, w[own], d});
            if (w[own]) ref_mem[a] = d;
            else if (!nord) rq.push_back({12'd0, 32'(cyc_n + 2), 4'(1 << own), ref_mem[a]});
        end
        @(posedge Clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(4'b0000, 4'b0000, 4'b0000, -1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {8'(i), ~8'(i)};
            ref_mem[i] = {8'(i), ~8'(i)};
        end
        mem[8'h15] = 16'h1234;
        ref_mem[8'h15] = 16'h1234;
        req = 4'b1111;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_gnt", 64'(gnt), 0);
        chk("reset_rvalid", 64'(rvalid), 0);
        chk("reset_rdata", 64'(rdata), 0);
        chk("reset_lock_timeout", 64'(lock_timeout), 0);
        chk("reset_ram_we", 64'(ram_we), 0);
        chk("reset_ram_addr_wdata", {ram_addr, ram_wdata}, 0);

        // all requesting: 0,1,0,2,0,3
        Reset_n = 1'b1;
        cycle(4'b1111, 0, 0, -1);
        cycle(4'b1111, 0, 0, 0);
        cycle(4'b1111, 0, 0, 1);
        cycle(4'b1111, 0, 0, 0);
        cycle(4'b1111, 0, 0, 2);
        cycle(4'b1111, 0, 0, 0);
        cycle(4'b1000, 0, 0, 3);
        idle(3);

        // single read of 0x15
        cycle(4'b0100, 0, 0, -1);
        cycle(4'b0100, 0, 0, 2);
        idle(3);

        // write 0xBEEF to 0x07 then read it back
        cycle(4'b0010, 0, 4'b0010, -1);
        cycle(4'b0010, 0, 4'b0010, 1);
        idle(1);
        cycle(4'b0010, 0, 0, -1);
        cycle(4'b0010, 0, 0, 1);
        idle(3);

        // lock held by 3 against req[0] until forced release
        cycle(4'b1000, 4'b1000, 0, -1);
        repeat (16) cycle(4'b1001, 4'b1000, 0, 3);
        tq.push_back(cyc_n);
        cycle(4'b0001, 0, 0, 0);
        idle(3);

        // 1 locks for 3 cycles, then round-robin continues 2, 3
        cycle(4'b1110, 4'b0010, 0, -1);
        cycle(4'b1110, 4'b0010, 0, 1);
        cycle(4'b1110, 4'b0010, 0, 1);
        cycle(4'b1110, 4'b0000, 0, 1);
        cycle(4'b1100, 0, 0, 2);
        cycle(4'b1000, 0, 0, 3);
        idle(3);

        // reset the cycle after a read grant: the read is discarded
        cycle(4'b0100, 0, 0, -1);
        cycle(4'b0100, 0, 0, 2, 1'b1);
        Reset_n = 1'b0;
        #1;
        chk("midreset_gnt", 64'(gnt), 0);
        chk("midreset_ram", {ram_addr, ram_we, ram_wdata}, 0);
        chk("midreset_rdata", 64'(rdata), 0);
        cycle(4'b0100, 0, 0, -1);
        cycle(4'b0100, 0, 0, -1);
        chk("midreset_rvalid", 64'(rvalid), 0);
        Reset_n = 1'b1;
        cycle(4'b0100, 0, 0, -1);
        cycle(4'b0100, 0, 0, 2);
        idle(4);

        chk("gnt_queue_drained", 64'(gq.size()), 0);
        chk("read_queue_drained", 64'(rq.size()), 0);
        chk("timeout_queue_drained", 64'(tq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
